// File: rtl/sent_pkg.sv
// Shared types, field widths and configuration limits for the SENT scheduler.
package sent_pkg;

  localparam int unsigned CH_W    = 8;
  localparam int unsigned CTICK_W = 8;
  localparam int unsigned LTICK_W = 8;
  localparam int unsigned PMODE_W = 2;
  localparam int unsigned PLEN_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned GAP_W   = 4;

  localparam int unsigned CTICK_MIN = 3;
  localparam int unsigned CTICK_MAX = 90;
  localparam int unsigned LTICK_MIN = 4;
  localparam int unsigned PAUSE_MIN = 12;
  localparam int unsigned PAUSE_MAX = 768;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE_CFG = 2'd1,
    ST_ISSUE_FRM = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  typedef struct packed {
    logic [CH_W-1:0]    channel;
    logic [CTICK_W-1:0] ctick_len;
    logic [LTICK_W-1:0] ltick_len;
    logic [PMODE_W-1:0] pause_mode;
    logic [PLEN_W-1:0]  pause_len;
    logic               crc_mode;
  } cfg_t;

  // Range check of a host configuration; pause length only matters when pause is enabled.
  function automatic logic cfg_valid(cfg_t c, int unsigned num_ch);
    logic ok;
    ok = (32'(c.channel) < num_ch)
      && (32'(c.ctick_len) >= CTICK_MIN) && (32'(c.ctick_len) <= CTICK_MAX)
      && (32'(c.ltick_len) >= LTICK_MIN);
    if (c.pause_mode != '0) begin
      ok = ok && (32'(c.pause_len) >= PAUSE_MIN) && (32'(c.pause_len) <= PAUSE_MAX);
    end
    return ok;
  endfunction

endpackage

// File: rtl/sent_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module sent_rr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    int unsigned j;
    j       = 0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!gnt_vld && req[IDX_W'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sent_sched.sv
// Scheduler serialising host config and per-channel frame requests onto the SENT channels.
// Optional saturating statistics counters are enabled by defining SENT_SCHED_STATS_EN.
module sent_sched
  import sent_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_req,
  input  logic [CH_W-1:0]          cfg_channel,
  input  logic [CTICK_W-1:0]       cfg_ctick_len,
  input  logic [LTICK_W-1:0]       cfg_ltick_len,
  input  logic [PMODE_W-1:0]       cfg_pause_mode,
  input  logic [PLEN_W-1:0]        cfg_pause_len,
  input  logic                     cfg_crc_mode,
  output logic                     cfg_ack,
  output logic                     cfg_err,
  input  logic [NUM_CH-1:0]        frm_req,
  input  logic [DATA_W*NUM_CH-1:0] frm_data,
  output logic [NUM_CH-1:0]        frm_ack,
  input  logic [NUM_CH-1:0]        ch_fifo_full,
  output logic                     sent_config_vld,
  output logic [CH_W-1:0]          sent_config_channel,
  output logic [CTICK_W-1:0]       sent_ctick_len,
  output logic [LTICK_W-1:0]       sent_ltick_len,
  output logic [PMODE_W-1:0]       sent_pause_mode,
  output logic [PLEN_W-1:0]        sent_pause_len,
  output logic                     sent_crc_mode,
  output logic [NUM_CH-1:0]        sent_frame_vld,
  output logic [DATA_W-1:0]        sent_frame_data
`ifdef SENT_SCHED_STATS_EN
  ,
  output logic [15:0]              frm_issued_cnt,
  output logic [7:0]               cfg_err_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                lwc_q, lwc_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  cfg_t                cfg_q, cfg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                cfg_ok_q, cfg_ok_d;
  logic                cfg_err_q, cfg_err_d;
  logic [NUM_CH-1:0]   frm_ack_q, frm_ack_d;

  cfg_t                cfg_in;
  logic [NUM_CH-1:0]   frm_elig;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_vld;
  logic                cfg_win;

  assign cfg_in   = '{channel:    cfg_channel,
                      ctick_len:  cfg_ctick_len,
                      ltick_len:  cfg_ltick_len,
                      pause_mode: cfg_pause_mode,
                      pause_len:  cfg_pause_len,
                      crc_mode:   cfg_crc_mode};
  assign frm_elig = frm_req & ~ch_fifo_full;

  sent_rr_arb #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (frm_elig),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // State and output registers; strobes are loaded at the IDLE decision so they show one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      lwc_q     <= 1'b0;
      gap_q     <= '0;
      cfg_q     <= '0;
      data_q    <= '0;
      cfg_ok_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      frm_ack_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lwc_q     <= lwc_d;
      gap_q     <= gap_d;
      cfg_q     <= cfg_d;
      data_q    <= data_d;
      cfg_ok_q  <= cfg_ok_d;
      cfg_err_q <= cfg_err_d;
      frm_ack_q <= frm_ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lwc_d     = lwc_q;
    gap_d     = gap_q;
    cfg_d     = cfg_q;
    data_d    = data_q;
    cfg_ok_d  = 1'b0;
    cfg_err_d = 1'b0;
    frm_ack_d = '0;
    cfg_win   = cfg_req && (!gnt_vld || !lwc_q);

    case (state_q)
      ST_IDLE: begin
        if (cfg_win) begin
          state_d = ST_ISSUE_CFG;
          lwc_d   = 1'b1;
          if (cfg_valid(cfg_in, NUM_CH)) begin
            cfg_ok_d = 1'b1;
            cfg_d    = cfg_in;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (gnt_vld) begin
          state_d = ST_ISSUE_FRM;
          lwc_d   = 1'b0;
          ptr_d   = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (IDX_W'(i) == gnt_idx) begin
              frm_ack_d[i] = 1'b1;
              data_d       = frm_data[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      ST_ISSUE_CFG, ST_ISSUE_FRM: begin
        state_d = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
        gap_d   = GAP_LOAD;
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cfg_ack             = cfg_ok_q;
  assign cfg_err             = cfg_err_q;
  assign frm_ack             = frm_ack_q;
  assign sent_config_vld     = cfg_ok_q;
  assign sent_config_channel = cfg_q.channel;
  assign sent_ctick_len      = cfg_q.ctick_len;
  assign sent_ltick_len      = cfg_q.ltick_len;
  assign sent_pause_mode     = cfg_q.pause_mode;
  assign sent_pause_len      = cfg_q.pause_len;
  assign sent_crc_mode       = cfg_q.crc_mode;
  assign sent_frame_vld      = frm_ack_q;
  assign sent_frame_data     = data_q;

`ifdef SENT_SCHED_STATS_EN
  // Counters follow the visible strobes, so a transaction lost to reset is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_issued_cnt <= '0;
      cfg_err_cnt    <= '0;
    end else begin
      if ((|frm_ack_q) && (frm_issued_cnt != 16'hFFFF)) begin
        frm_issued_cnt <= frm_issued_cnt + 16'd1;
      end
      if (cfg_err_q && (cfg_err_cnt != 8'hFF)) begin
        cfg_err_cnt <= cfg_err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
